// File: rtl/risc_pkg.sv
// Shared definitions for the scoreboarded register file.
//   DATA_W_DEF / ADDR_W_DEF : default data and address widths
//   REG_ZERO                : hard-wired zero register index
//   pend_width()            : width of a per-register pending-write counter
package risc_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  // A counter must hold 0..max_pend inclusive; never narrower than one bit.
  function automatic int pend_width(input int max_pend);
    return (max_pend < 1) ? 1 : $clog2(max_pend + 1);
  endfunction

endpackage

// File: rtl/risc_regfile_sb_if.sv
// Bus bundle between a pipeline (master) and the scoreboarded register file
// (slave).
//   raddr/rdata/rbusy : packed read ports, port i at [i*W +: W]
//   wen/waddr/wdata   : write-back, also retires one pending write
//   iss_en/iss_addr   : destination of an issuing instruction
//   iss_full          : issue would exceed the pending limit
//   flush             : drop all pending-write tracking
//   err               : sticky retire-without-pending indication
interface risc_regfile_sb_if
  import risc_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int RD_PORTS = 2
);

  logic [RD_PORTS*ADDR_W-1:0] raddr;
  logic [RD_PORTS*DATA_W-1:0] rdata;
  logic [RD_PORTS-1:0]        rbusy;
  logic                       wen;
  logic [ADDR_W-1:0]          waddr;
  logic [DATA_W-1:0]          wdata;
  logic                       iss_en;
  logic [ADDR_W-1:0]          iss_addr;
  logic                       iss_full;
  logic                       flush;
  logic                       err;

  modport master (
    output raddr, wen, waddr, wdata, iss_en, iss_addr, flush,
    input  rdata, rbusy, iss_full, err
  );

  modport slave (
    input  raddr, wen, waddr, wdata, iss_en, iss_addr, flush,
    output rdata, rbusy, iss_full, err
  );

endinterface

// File: rtl/risc_regfile_sb_scoreboard.sv
// Pending-write scoreboard: one saturating-by-rejection counter per register.
// Inputs : clk, rst_n, iss_en_i/iss_addr_i, wen_i/waddr_i, flush_i
// Outputs: iss_full_o, err_o (sticky), busy_o[r] (pend!=0), last_o[r] (pend==1)
module rf_scoreboard
  import risc_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MAX_PEND = 3,
  localparam int NREG    = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_en_i,
  input  logic [ADDR_W-1:0] iss_addr_i,
  input  logic              wen_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic              flush_i,
  output logic              iss_full_o,
  output logic              err_o,
  output logic [NREG-1:0]   busy_o,
  output logic [NREG-1:0]   last_o
);

  localparam int PEND_W = pend_width(MAX_PEND);
  localparam logic [PEND_W-1:0] MAX_CNT = PEND_W'(MAX_PEND);
  localparam logic [PEND_W-1:0] ONE_CNT = PEND_W'(1);

  logic [PEND_W-1:0] pend_q [NREG];
  logic [PEND_W-1:0] pend_d [NREG];
  logic              err_q, err_d;

  logic iss_nz, ret_nz, same_ret, full_raw, iss_acc, ret_ok, ret_bad;

  assign iss_nz   = (iss_addr_i != ADDR_W'(REG_ZERO));
  assign ret_nz   = (waddr_i != ADDR_W'(REG_ZERO));
  assign same_ret = wen_i && ret_nz && (waddr_i == iss_addr_i);

  // A same-cycle retire to the full register frees a slot, so the issue fits.
  assign full_raw = iss_en_i && iss_nz && (pend_q[iss_addr_i] == MAX_CNT) && !same_ret;
  assign iss_acc  = iss_en_i && iss_nz && !full_raw;
  assign ret_ok   = wen_i && ret_nz && (pend_q[waddr_i] != '0);
  assign ret_bad  = wen_i && ret_nz && (pend_q[waddr_i] == '0);

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      logic inc, dec;
      inc = iss_acc && (iss_addr_i == ADDR_W'(r));
      dec = ret_ok  && (waddr_i == ADDR_W'(r));
      pend_d[r] = pend_q[r];
      if (flush_i)          pend_d[r] = '0;
      else if (inc && !dec) pend_d[r] = pend_q[r] + ONE_CNT;
      else if (dec && !inc) pend_d[r] = pend_q[r] - ONE_CNT;
    end
  end

  // flush only touches counters; the error flag keeps accumulating.
  assign err_d = err_q | ret_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) pend_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) pend_q[r] <= pend_d[r];
      err_q <= err_d;
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      busy_o[r] = (pend_q[r] != '0);
      last_o[r] = (pend_q[r] == ONE_CNT);
    end
  end

  assign iss_full_o = rst_n && full_raw;
  assign err_o      = err_q;

endmodule

// File: rtl/risc_regfile_sb.sv
// Register file with per-register pending-write scoreboard.
// Ports: clk, rst_n (async, active-low), bus (risc_regfile_sb_if.slave).
// Register 0 reads as zero and ignores writes/issues.
// Optional feature macro RF_BYPASS_EN: same-cycle write-through on reads and
// early clearing of rbusy when the write retires the last pending write.
module risc_regfile_sb
  import risc_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int RD_PORTS = 2,
  parameter int MAX_PEND = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  risc_regfile_sb_if.slave      bus
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0]          regs_q [NREG];
  logic [NREG-1:0]            busy_vec, last_vec;
  logic [RD_PORTS*DATA_W-1:0] rdata_c;
  logic [RD_PORTS-1:0]        rbusy_c;
  logic                       wr_nz;

  assign wr_nz = bus.wen && (bus.waddr != ADDR_W'(REG_ZERO));

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .MAX_PEND (MAX_PEND)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .iss_en_i   (bus.iss_en),
    .iss_addr_i (bus.iss_addr),
    .wen_i      (bus.wen),
    .waddr_i    (bus.waddr),
    .flush_i    (bus.flush),
    .iss_full_o (bus.iss_full),
    .err_o      (bus.err),
    .busy_o     (busy_vec),
    .last_o     (last_vec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
    end else if (wr_nz) begin
      regs_q[bus.waddr] <= bus.wdata;
    end
  end

  always_comb begin
    rdata_c = '0;
    rbusy_c = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      logic [ADDR_W-1:0] ra;
      logic              ra_nz;
      logic [DATA_W-1:0] rd;
      logic              rb;
      ra    = bus.raddr[i*ADDR_W +: ADDR_W];
      ra_nz = (ra != ADDR_W'(REG_ZERO));
      rd    = ra_nz ? regs_q[ra] : '0;
      rb    = ra_nz && busy_vec[ra];
`ifdef RF_BYPASS_EN
      // Forwarding is suppressed in reset so outputs read zero while held.
      if (rst_n && wr_nz && (bus.waddr == ra)) begin
        rd = bus.wdata;
        if (last_vec[ra] && !(bus.iss_en && (bus.iss_addr == ra))) rb = 1'b0;
      end
`endif
      rdata_c[i*DATA_W +: DATA_W] = rd;
      rbusy_c[i]                  = rb;
    end
  end

`ifndef RF_BYPASS_EN
  logic unused_last;
  assign unused_last = ^last_vec;
`endif

  assign bus.rdata = rdata_c;
  assign bus.rbusy = rbusy_c;

endmodule

// File: tb/tb_risc_regfile_sb.sv
module tb_risc_regfile_sb;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  risc_regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .RD_PORTS(2)) bus ();

  risc_regfile_sb #(
    .DATA_W(32), .ADDR_W(5), .RD_PORTS(2), .MAX_PEND(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wen      = 1'b0;
    bus.waddr    = '0;
    bus.wdata    = '0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  function automatic logic [31:0] rd0();
    return bus.rdata[31:0];
  endfunction

  function automatic logic [31:0] rd1();
    return bus.rdata[63:32];
  endfunction

  initial begin
    idle_inputs();
    bus.raddr = '0;
    rst_n = 1'b0;
    #3;
    check_val("rst_hold_err",  bus.err, 0);
    check_val("rst_hold_full", bus.iss_full, 0);
    do_reset();

    // reset state: every register on both ports
    for (int r = 0; r < 32; r++) begin
      bus.raddr = {5'(r), 5'(r)};
      #1;
      check_val($sformatf("rst_rd_r%0d", r), {bus.rdata, 2'b00, bus.rbusy}, 0);
    end
    check_val("rst_err", bus.err, 0);

    // r0: write and issue ignored
    bus.raddr = '0;
    bus.wen = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFF_FFFF;
    bus.iss_en = 1'b1; bus.iss_addr = 5'd0;
    #1;
    check_val("r0_full", bus.iss_full, 0);
    check_val("r0_rd_same", rd0(), 0);
    tick();
    idle_inputs();
    #1;
    check_val("r0_rd", rd0(), 0);
    check_val("r0_busy", bus.rbusy, 0);
    check_val("r0_err", bus.err, 0);

    // r7: fill to MAX_PEND, boundary with simultaneous retire, then reject
    bus.raddr = {5'd7, 5'd7};
    for (int k = 0; k < 3; k++) begin
      bus.iss_en = 1'b1; bus.iss_addr = 5'd7;
      tick();
    end
    bus.iss_en = 1'b0;
    #1;
    check_val("r7_busy3", bus.rbusy, 2'b11);
    bus.iss_en = 1'b1; bus.iss_addr = 5'd7;
    bus.wen = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'hA0;
    #1;
    check_val("r7_full_w_retire", bus.iss_full, 0);
    tick();
    bus.wen = 1'b0;
    #1;
    check_val("r7_full_4th", bus.iss_full, 1);
    tick();
    bus.iss_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.wen = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'hB0 + 32'(k);
      #1;
      if (k < 2) check_val($sformatf("r7_busy_ret%0d", k), bus.rbusy[0], 1);
      else       check_val("r7_busy_last_same", bus.rbusy[0], BYP ? 1'b0 : 1'b1);
      tick();
      bus.wen = 1'b0;
    end
    #1;
    check_val("r7_busy_clear", bus.rbusy, 0);
    check_val("r7_data", rd0(), 32'hB2);
    check_val("r7_err", bus.err, 0);

    // r3: simultaneous issue+retire at pend=1, then flush
    bus.raddr = {5'd3, 5'd3};
    bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
    tick();
    bus.wen = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'h33;
    #1;
    check_val("r3_busy_same", bus.rbusy[1], 1);
    tick();
    idle_inputs();
    #1;
    check_val("r3_busy_after", bus.rbusy[1], 1);
    check_val("r3_data", rd1(), 32'h33);
    bus.flush = 1'b1;
    #1;
    check_val("r3_busy_preflush", bus.rbusy[1], 1);
    tick();
    bus.flush = 1'b0;
    #1;
    check_val("r3_busy_flushed", bus.rbusy, 0);
    check_val("r3_err", bus.err, 0);

    // r5: write with same-cycle read; no pending write so err sets
    bus.raddr = {5'd0, 5'd5};
    bus.wen = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'h1234_5678;
    #1;
    check_val("r5_rd_same", rd0(), BYP ? 32'h1234_5678 : 32'h0);
    tick();
    bus.wen = 1'b0;
    #1;
    check_val("r5_rd_next", rd0(), 32'h1234_5678);
    check_val("r5_err", bus.err, 1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    check_val("r5_err_after_flush", bus.err, 1);

    // reset clears err and data
    rst_n = 1'b0;
    #1;
    check_val("rst2_err", bus.err, 0);
    check_val("rst2_r5", rd0(), 0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // r9: retire with pend=0 still writes, err sticky
    bus.raddr = {5'd0, 5'd9};
    bus.wen = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'h99;
    tick();
    bus.wen = 1'b0;
    #1;
    check_val("r9_data", rd0(), 32'h99);
    check_val("r9_err", bus.err, 1);
    repeat (3) tick();
    check_val("r9_err_sticky", bus.err, 1);

    // r4: reset mid-sequence with pend=2 and write in flight
    do_reset();
    bus.raddr = {5'd0, 5'd4};
    repeat (2) begin
      bus.iss_en = 1'b1; bus.iss_addr = 5'd4;
      tick();
    end
    bus.iss_en = 1'b0;
    #1;
    check_val("r4_busy", bus.rbusy[0], 1);
    bus.wen = 1'b1; bus.waddr = 5'd4; bus.wdata = 32'h44;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("r4_rst_busy", bus.rbusy, 0);
    check_val("r4_rst_rd", rd0(), 0);
    check_val("r4_rst_err", bus.err, 0);
    check_val("r4_rst_full", bus.iss_full, 0);
    idle_inputs();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_val("r4_post_busy", bus.rbusy, 0);
    check_val("r4_post_rd", rd0(), 0);
    check_val("r4_post_err", bus.err, 0);
    bus.wen = 1'b1; bus.waddr = 5'd4; bus.wdata = 32'h55;
    tick();
    bus.wen = 1'b0;
    #1;
    check_val("r4_retire_data", rd0(), 32'h55);
    check_val("r4_retire_err", bus.err, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
